// File: rtl/tron_pkg.sv
// ---------------------------------------------------------------------------
// tron_pkg
// Shared constants for the Tron frame scheduler: the screen geometry, the
// tile size, the scheduler state encoding, the update bit mapping and the
// player snapshot record.
// ---------------------------------------------------------------------------
package tron_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int TILE     = 4;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  // Scheduler states, kept as plain constants so older tools can read them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_DRAW_A = 3'd5;
  localparam logic [2:0] ST_DRAW_B = 3'd6;

  // Bit n of the update port goes to player n.
  localparam int UPD_P0 = 0;
  localparam int UPD_P1 = 1;

  // One player's tile origin and colour, captured once per step.
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } tile_src_t;

  // True when a widened pixel coordinate lands inside the visible screen.
  function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
    return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer
// Paces the game: a delay counter produces one tick per video frame and a
// frame counter turns every FRAMES_PER_STEP-th tick into a step expiry.
//
// Ports:
//   clk     in   system clock
//   resetn  in   synchronous active-low reset
//   hold    in   keep both counters at their reload values
//   expire  out  high for the one cycle in which a game step expires
// ---------------------------------------------------------------------------
module frame_timer #(
  parameter int FRAME_TICKS     = 833334,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic hold,
  output logic expire
);

  localparam int DW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [DW-1:0] RELOAD = DW'(FRAME_TICKS - 1);
  localparam logic [FW-1:0] LAST   = FW'(FRAMES_PER_STEP - 1);

  logic [DW-1:0] delay;
  logic [FW-1:0] frames;
  logic          tick;

  assign tick   = !hold && (delay == '0);
  assign expire = tick && (frames == LAST);

  // Delay counts down and reloads on its tick; frames counts ticks and
  // wraps on the expiring one. Holding parks both at their start values.
  always_ff @(posedge clk) begin
    if (!resetn || hold) begin
      delay  <= RELOAD;
      frames <= '0;
    end else if (tick) begin
      delay  <= RELOAD;
      frames <= (frames == LAST) ? '0 : frames + 1'b1;
    end else begin
      delay <= delay - 1'b1;
    end
  end

endmodule

// File: rtl/tron_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tron_frame_scheduler
// Shares the single vga_adapter plot port between two light-cycle datapaths
// and a full-screen clear. Each game step it pulses both players' update,
// snapshots their positions and draws both 4x4 tiles back to back, swapping
// which player goes first every step.
//
// Ports:
//   clk, resetn            clock and synchronous active-low reset
//   go                     start request, only looked at in IDLE
//   clear_req              full-screen clear request
//   p0_x/p0_y/p0_colour    player 0 tile origin and colour
//   p1_x/p1_y/p1_colour    player 1 tile origin and colour
//   update                 one-cycle step pulse, bit n to player n
//   x/y/colour/plot        registered pixel port to vga_adapter
//   busy                   scheduler is clearing or running a step
//   step_done              one-cycle pulse once both tiles are drawn
// ---------------------------------------------------------------------------
module tron_frame_scheduler
  import tron_pkg::*;
#(
  parameter int FRAME_TICKS     = 833334,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       clear_req,
  input  logic [7:0] p0_x,
  input  logic [6:0] p0_y,
  input  logic [2:0] p0_colour,
  input  logic [7:0] p1_x,
  input  logic [6:0] p1_y,
  input  logic [2:0] p1_colour,
  output logic [1:0] update,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       step_done
);

  logic [2:0] state, state_nx;
  logic       order;
  logic       clr_pend;
  logic [3:0] t;
  logic [7:0] clr_x;
  logic [6:0] clr_y;
  tile_src_t  snap0, snap1, cur;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       expire, hold;
  logic       clear_end, tile_end;
  logic       state_busy, busy_tail;

  assign hold      = (state == ST_IDLE) || (state == ST_CLEAR);
  assign clear_end = (clr_x == 8'(SCREEN_W - 1)) && (clr_y == 7'(SCREEN_H - 1));
  assign tile_end  = (t == 4'(TILE * TILE - 1));

  frame_timer #(
    .FRAME_TICKS    (FRAME_TICKS),
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_frame_timer (
    .clk   (clk),
    .resetn(resetn),
    .hold  (hold),
    .expire(expire)
  );

  // busy_tail keeps busy up for the cycle in which the last registered pixel
  // of a clear or step is still being presented on the port.
  assign state_busy = (state != ST_IDLE) && (state != ST_WAIT);
  assign busy       = state_busy || busy_tail;

  always_comb begin
    update         = 2'b00;
    update[UPD_P0] = (state == ST_UPDATE);
    update[UPD_P1] = (state == ST_UPDATE);
  end

  // DRAW_A takes player 0 when order is 0, DRAW_B takes the other one.
  always_comb begin
    cur   = (((state == ST_DRAW_A) ? 1'b1 : 1'b0) ^ order) ? snap0 : snap1;
    sum_x = {1'b0, cur.x} + {7'd0, t[1:0]};
    sum_y = {1'b0, cur.y} + {6'd0, t[3:2]};
  end

  // Next-state logic. In WAIT a clear request beats an expiring step; a clear
  // seen while a step is running is deferred until DRAW_B has finished.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (go) state_nx = ST_CLEAR;
      ST_CLEAR:  if (clear_end) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (clear_req)   state_nx = ST_CLEAR;
        else if (expire) state_nx = ST_UPDATE;
      end
      ST_UPDATE: state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = ST_DRAW_A;
      ST_DRAW_A: if (tile_end) state_nx = ST_DRAW_B;
      ST_DRAW_B: if (tile_end) state_nx = (clr_pend || clear_req) ? ST_CLEAR : ST_WAIT;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State, counters, snapshots and the registered pixel port. plot drops to
  // 0 in every cycle that is not producing a pixel; x/y/colour just hold.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      order     <= 1'b0;
      clr_pend  <= 1'b0;
      t         <= '0;
      clr_x     <= '0;
      clr_y     <= '0;
      snap0     <= '0;
      snap1     <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      step_done <= 1'b0;
      busy_tail <= 1'b0;
    end else begin
      state     <= state_nx;
      plot      <= 1'b0;
      step_done <= 1'b0;
      busy_tail <= state_busy;
      case (state)
        ST_CLEAR: begin
          x        <= clr_x;
          y        <= clr_y;
          colour   <= COLOUR_BLACK;
          plot     <= 1'b1;
          clr_pend <= 1'b0;
          if (clr_x == 8'(SCREEN_W - 1)) begin
            clr_x <= '0;
            clr_y <= clear_end ? '0 : clr_y + 7'd1;
          end else begin
            clr_x <= clr_x + 8'd1;
          end
        end
        ST_UPDATE: clr_pend <= clear_req;
        ST_SETTLE: begin
          snap0    <= '{x: p0_x, y: p0_y, colour: p0_colour};
          snap1    <= '{x: p1_x, y: p1_y, colour: p1_colour};
          t        <= '0;
          clr_pend <= clr_pend || clear_req;
        end
        ST_DRAW_A, ST_DRAW_B: begin
          // Off-screen pixels still consume their slot, just without a write.
          x        <= sum_x[7:0];
          y        <= sum_y[6:0];
          colour   <= cur.colour;
          plot     <= on_screen(sum_x, sum_y);
          t        <= t + 4'd1;
          clr_pend <= clr_pend || clear_req;
          if (state == ST_DRAW_B && tile_end) begin
            order     <= ~order;
            step_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tron_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tron_frame_scheduler
// Self-checking bench for tron_frame_scheduler with a short frame timer.
// Expected timing comes from step arithmetic: the timer releases on the
// first WAIT cycle after a clear, and steps expire every FT*FPS cycles from
// there. Tiles, order and clipping are predicted from the player positions.
// ---------------------------------------------------------------------------
module tb_tron_frame_scheduler;

  localparam int FT     = 4;
  localparam int FPS    = 2;
  localparam int PERIOD = FT * FPS;
  localparam int SW     = 160;
  localparam int SH     = 120;
  localparam int NPIX   = SW * SH;

  logic       clk = 1'b0;
  logic       resetn, go, clear_req;
  logic [7:0] p0_x, p1_x;
  logic [6:0] p0_y, p1_y;
  logic [2:0] p0_colour, p1_colour;
  logic [1:0] update;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, step_done;

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int waitEntry = 0;
  int timerBase = 0;
  int stepCount = 0;

  tron_frame_scheduler #(
    .FRAME_TICKS    (FT),
    .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .go       (go),
    .clear_req(clear_req),
    .p0_x     (p0_x),
    .p0_y     (p0_y),
    .p0_colour(p0_colour),
    .p1_x     (p1_x),
    .p1_y     (p1_y),
    .p1_colour(p1_colour),
    .update   (update),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .step_done(step_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int ax, input int ay, input int ac,
                               input int bx, input int by, input int bc);
    p0_x = 8'(ax); p0_y = 7'(ay); p0_colour = 3'(ac);
    p1_x = 8'(bx); p1_y = 7'(by); p1_colour = 3'(bc);
  endtask

  // First step-expiry cycle at or after 'from'.
  function automatic int expiryAfter(input int from);
    int r;
    r = (from - timerBase) % PERIOD;
    return from + (PERIOD - 1 - r);
  endfunction

  // Checks n pixels of a clear whose first pixel is visible in cycle f.
  task automatic runClear(input int f, input int n);
    int bad = 0;
    while (cyc < f - 1) begin
      nextCycle();
      checkOutput("pre_clear_plot", plot, 0);
    end
    for (int k = 0; k < n; k++) begin
      nextCycle();
      if (plot !== 1'b1 || x !== 8'(k % SW) || y !== 7'(k / SW) ||
          colour !== 3'd0 || busy !== 1'b1)
        bad++;
      if (k == 0) begin
        checkOutput("clear_first_x", x, 0);
        checkOutput("clear_first_y", y, 0);
      end
      if (k == NPIX - 1) begin
        checkOutput("clear_last_x", x, 159);
        checkOutput("clear_last_y", y, 119);
        checkOutput("clear_last_busy", busy, 1);
      end
    end
    checkOutput("clear_bad_pixels", bad, 0);
    waitEntry = cyc;
    timerBase = cyc;
  endtask

  // One game step. mode 0: plain, 1: clear_req pulse during DRAW_A,
  // 2: reset at DRAW_A t=7.
  task automatic runStep(input int mode, input int ax, input int ay, input int ac,
                         input int bx, input int by, input int bc);
    int e, sx, sy, sc, t, px, py;
    logic ep;
    e = expiryAfter(waitEntry);
    while (cyc < e) begin
      nextCycle();
      checkOutput("wait_update", update, 0);
      checkOutput("wait_plot", plot, 0);
      checkOutput("wait_busy", busy, 0);
    end
    nextCycle();
    checkOutput("update_pulse", update, 2'b11);
    checkOutput("update_busy", busy, 1);
    applyStimulus(ax, ay, ac, bx, by, bc);
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      checkOutput("settle_update", update, 0);
      checkOutput("settle_plot", plot, 0);
    end
    for (int i = 0; i < 32; i++) begin
      nextCycle();
      // Player 0 goes first on even steps since reset.
      if ((i < 16) == (stepCount % 2 == 0)) begin sx = ax; sy = ay; sc = ac; end
      else begin sx = bx; sy = by; sc = bc; end
      t  = i % 16;
      px = sx + t % 4;
      py = sy + t / 4;
      ep = (px < SW) && (py < SH);
      checkOutput("tile_plot", plot, ep);
      if (ep) begin
        checkOutput("tile_x", x, px);
        checkOutput("tile_y", y, py);
        checkOutput("tile_colour", colour, sc);
      end
      checkOutput("tile_busy", busy, 1);
      checkOutput("tile_step_done", step_done, (i == 31) ? 1 : 0);
      if (mode == 1 && i == 1) clear_req = 1'b1;
      if (mode == 1 && i == 2) clear_req = 1'b0;
      if (mode == 2 && i == 6) begin
        resetn = 1'b0;
        nextCycle();
        checkOutput("rst_plot", plot, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_update", update, 0);
        checkOutput("rst_step_done", step_done, 0);
        checkOutput("rst_x", x, 0);
        checkOutput("rst_y", y, 0);
        checkOutput("rst_colour", colour, 0);
        stepCount = 0;
        return;
      end
    end
    stepCount++;
    if (mode == 1) runClear(e + 36, NPIX);
    else waitEntry = e + 35;
  endtask

  // Holds clear_req across the expiry cycle in WAIT: the clear must win.
  task automatic clearInWait();
    int e;
    e = expiryAfter(waitEntry);
    while (cyc < e) begin
      nextCycle();
      checkOutput("cw_update", update, 0);
      checkOutput("cw_plot", plot, 0);
    end
    clear_req = 1'b1;
    nextCycle();
    checkOutput("cw_no_update", update, 0);
    checkOutput("cw_busy", busy, 1);
    clear_req = 1'b0;
    runClear(e + 2, NPIX);
  endtask

  initial begin
    int c;
    resetn = 1'b0; go = 1'b0; clear_req = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) nextCycle();
    checkOutput("reset_plot", plot, 0);
    checkOutput("reset_update", update, 0);
    checkOutput("reset_x", x, 0);
    checkOutput("reset_y", y, 0);
    checkOutput("reset_colour", colour, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_step_done", step_done, 0);
    resetn = 1'b1;
    nextCycle();
    checkOutput("idle_plot", plot, 0);

    c = cyc; go = 1'b1;
    nextCycle(); go = 1'b0;
    runClear(c + 2, NPIX);

    $display("[TB] directed steps");
    runStep(0, 10, 20, 4, 50, 60, 2);
    runStep(0, 10, 20, 4, 50, 60, 2);
    runStep(0, 10, 20, 4, 50, 60, 2);
    runStep(0, 158, 118, 5, 50, 60, 2);
    runStep(0, 158, 118, 5, 50, 60, 2);

    $display("[TB] random steps");
    go = 1'b1;
    for (int s = 0; s < 8; s++)
      runStep(0, $urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 7),
                 $urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 7));
    go = 1'b0;

    $display("[TB] clear requests");
    runStep(1, 30, 40, 1, 70, 80, 6);
    runStep(0, 30, 40, 1, 70, 80, 6);
    clearInWait();

    $display("[TB] reset behaviour");
    runStep(2, 100, 100, 3, 20, 10, 7);
    nextCycle();
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      nextCycle();
      checkOutput("post_rst_plot", plot, 0);
      checkOutput("post_rst_busy", busy, 0);
    end
    c = cyc; go = 1'b1;
    nextCycle(); go = 1'b0;
    runClear(c + 2, 300);
    resetn = 1'b0;
    nextCycle();
    checkOutput("rst_clear_plot", plot, 0);
    checkOutput("rst_clear_busy", busy, 0);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      checkOutput("rst_clear_idle_plot", plot, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
